// File: rtl/branch_target_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : branch_target_buffer
//  Description : Direct-mapped branch target buffer for the IF stage.
//                Combinational lookup on the fetch PC, training from the EX
//                stage, and saturating branch statistics counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_target_buffer #(
    parameter int IDX_BITS = 3,
    parameter int CNT_BITS = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         PCF,
    input  logic [31:0]         PCE,
    input  logic [31:0]         BrNPC,
    input  logic                BranchE,
    input  logic [2:0]          BranchTypeE,
    output logic                BTBhit,
    output logic [31:0]         PredictedPC,
    output logic [CNT_BITS-1:0] BranchCnt,
    output logic [CNT_BITS-1:0] TakenCnt,
    output logic [CNT_BITS-1:0] CorrectTgtCnt
);

    localparam int                  c_ENTRIES  = 1 << IDX_BITS;
    localparam int                  c_TAG_BITS = 30 - IDX_BITS;
    localparam logic [CNT_BITS-1:0] c_CNT_MAX  = {CNT_BITS{1'b1}};

    // Table storage: only the valid bits are reset; tag/target are
    // meaningless while their valid bit is clear.
    logic [c_ENTRIES-1:0]  r_valid;
    logic [c_TAG_BITS-1:0] r_tag    [c_ENTRIES];
    logic [31:0]           r_target [c_ENTRIES];

    logic [CNT_BITS-1:0]   r_branch_cnt;
    logic [CNT_BITS-1:0]   r_taken_cnt;
    logic [CNT_BITS-1:0]   r_correct_cnt;

    logic [IDX_BITS-1:0]   w_idx_f;
    logic [IDX_BITS-1:0]   w_idx_e;
    logic [c_TAG_BITS-1:0] w_tag_f;
    logic [c_TAG_BITS-1:0] w_tag_e;
    logic                  w_hit_f;
    logic                  w_hit_e;
    logic [31:0]           w_target_e;
    logic                  w_correct_e;
    logic                  w_unused;

    // PC[1:0] is a byte offset within the instruction word and never matters.
    assign w_unused = ^{PCF[1:0], PCE[1:0]};

    assign w_idx_f = PCF[IDX_BITS+1:2];
    assign w_tag_f = PCF[31:IDX_BITS+2];
    assign w_idx_e = PCE[IDX_BITS+1:2];
    assign w_tag_e = PCE[31:IDX_BITS+2];

    // Fetch-side lookup; held quiet while reset is asserted.
    always_comb begin
        w_hit_f     = 1'b0;
        PredictedPC = 32'h0;
        if (!rst && r_valid[w_idx_f] && (r_tag[w_idx_f] == w_tag_f)) begin
            w_hit_f     = 1'b1;
            PredictedPC = r_target[w_idx_f];
        end
    end

    assign BTBhit = w_hit_f;

    // EX-side probe of pre-write contents, used only for target-accuracy stats.
    always_comb begin
        w_hit_e    = r_valid[w_idx_e] && (r_tag[w_idx_e] == w_tag_e);
        w_target_e = r_target[w_idx_e];
    end

    assign w_correct_e = BranchE && w_hit_e && (w_target_e == BrNPC);

    // Table update: a taken resolution always (re)allocates its entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else if (BranchE) begin
            r_valid[w_idx_e]  <= 1'b1;
            r_tag[w_idx_e]    <= w_tag_e;
            r_target[w_idx_e] <= BrNPC;
        end
    end

    // Saturating statistics counters; they stick at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_branch_cnt  <= '0;
            r_taken_cnt   <= '0;
            r_correct_cnt <= '0;
        end else begin
            if ((BranchTypeE != 3'd0) && (r_branch_cnt != c_CNT_MAX)) begin
                r_branch_cnt <= r_branch_cnt + 1'b1;
            end
            if (BranchE && (r_taken_cnt != c_CNT_MAX)) begin
                r_taken_cnt <= r_taken_cnt + 1'b1;
            end
            if (w_correct_e && (r_correct_cnt != c_CNT_MAX)) begin
                r_correct_cnt <= r_correct_cnt + 1'b1;
            end
        end
    end

    assign BranchCnt     = r_branch_cnt;
    assign TakenCnt      = r_taken_cnt;
    assign CorrectTgtCnt = r_correct_cnt;

endmodule
`default_nettype wire

// File: doc/branch_target_buffer.md
# branch_target_buffer

Direct-mapped branch target buffer in the IF stage. It looks up the fetch PC every cycle and returns a hit flag and a predicted target. `BTBhit` feeds the downstream direction predictor, which gates it with its 2-bit state; `PredictedPC` goes to the NPC mux. The table is trained from the EX stage with the resolved branch outcome and target, and the block keeps saturating statistics counters for the performance report.

## Interface
- `IDX_BITS`, 3, index width; the table holds 2^IDX_BITS entries (8 by default).
- `CNT_BITS`, 16, width of each statistics counter.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high; sampled on the rising edge of `clk`.
- `PCF`  in  32  fetch-stage PC; lookup address.
- `PCE`  in  32  EX-stage PC of the instruction being resolved.
- `BrNPC`  in  32  resolved branch target computed in EX.
- `BranchE`  in  1  EX branch resolved taken.
- `BranchTypeE`  in  3  EX branch type; 0 means not a conditional branch.
- `BTBhit`  out  1  valid entry with matching tag at `PCF`.
- `PredictedPC`  out  32  stored target for `PCF`; 0 when `BTBhit`=0.
- `BranchCnt`  out  CNT_BITS  count of resolved branches (`BranchTypeE`!=0).
- `TakenCnt`  out  CNT_BITS  count of resolved taken branches.
- `CorrectTgtCnt`  out  CNT_BITS  count of taken branches whose entry hit with target == `BrNPC`.

## Operation
- Entry format: `valid` (1), `tag` (32-IDX_BITS-2), `target` (32).
- Address split for any PC: index = PC[IDX_BITS+1:2], tag = PC[31:IDX_BITS+2]. PC[1:0] is ignored.
- Lookup is combinational on `PCF`.
  - `BTBhit` = valid[idx] & (tag[idx]==tag(PCF)).
  - `PredictedPC` = target[idx] when hit, else 32'h0.
- EX probe is a second combinational read at `PCE`, producing `hitE` and `targetE`. Both are internal only.
- Update on a clock edge with `rst`=0:
  - `BranchE`=1: write entry[idx(PCE)] = {1, tag(PCE), BrNPC}. This unconditionally replaces an aliasing entry and refreshes a stale target.
  - `BranchE`=0, `BranchTypeE`!=0: no table change. Direction is owned by the BHT.
  - `BranchE`=0, `BranchTypeE`=0: no change.
- Counters on a clock edge with `rst`=0. Each saturates at all-ones and never wraps.
  - `BranchCnt` +1 if `BranchTypeE`!=0.
  - `TakenCnt` +1 if `BranchE`=1.
  - `CorrectTgtCnt` +1 if `BranchE`=1 & `hitE` & `targetE`==BrNPC. This uses pre-write contents.
- `BranchE`=1 with `BranchTypeE`=0 is treated as taken. It writes the table, increments `TakenCnt`, and does not increment `BranchCnt`.

## Timing
- Reset: on a rising edge with `rst`=1, all valid bits and all three counters clear to 0. Tag and target contents are don't-care.
  - While `rst`=1, `BTBhit` is forced to 0 and `PredictedPC` to 0 combinationally.
  - Reset has priority over a same-cycle update.
  - Reset asserted mid-training discards that cycle's write.
- Lookup latency is 0 cycles (same-cycle combinational).
- A write becomes visible to lookups from the cycle after the edge that performs it.
- Same-cycle `PCF` and `PCE` to the same index: the lookup returns old contents (read-before-write, no bypass).
- The EX probe likewise sees pre-write contents, so `CorrectTgtCnt` never counts its own write.
- No stall input: the block updates on every EX resolution presented. Holding EX inputs constant across stalls is the caller's duty.
- Counter saturation: with a counter at 2^CNT_BITS-1, a qualifying event leaves it unchanged.

## Test plan
- Reset then probe: assert `rst` 1 cycle, then sweep `PCF` over 0x00..0x3C → `BTBhit`=0 and `PredictedPC`=0 throughout; all counters read 0.
- Train and hit:
  - Inputs: `PCE`=0x0000_0010, `BrNPC`=0x0000_0040, `BranchE`=1, `BranchTypeE`=1 for 1 cycle.
  - Same-cycle `PCF`=0x10 → `BTBhit`=0.
  - Next cycle `PCF`=0x10 → `BTBhit`=1, `PredictedPC`=0x40.
  - `TakenCnt`=1, `BranchCnt`=1, `CorrectTgtCnt`=0.
- Alias replace: after the training above, train `PCE`=0x0000_0030 (same index 4, different tag) → `BrNPC`=0x80. Then `PCF`=0x10 → miss; `PCF`=0x30 → hit with target 0x80.
- Not-taken keeps entry: with 0x10→0x40 stored, `BranchE`=0, `BranchTypeE`=1, `PCE`=0x10 → entry unchanged; `BranchCnt`+1, `TakenCnt` unchanged.
- Correct-target count:
  - Re-resolve 0x10 taken with `BrNPC`=0x40 → `CorrectTgtCnt`=1.
  - Then resolve with `BrNPC`=0x44 → `CorrectTgtCnt` unchanged, and the next lookup returns 0x44.
- Saturation and reset priority: with `CNT_BITS`=4, issue 20 taken resolutions → `TakenCnt`=15. Assert `rst` together with a taken update → all counters 0, and `PCF`=`PCE` misses on the following cycle.
